multicycle_adder: RTL

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first, through a registered carry chain. It generalises the single-bit full adder to arbitrary width with a start/done handshake, a subtract mode and status flags (carry, signed overflow, zero). It sits between an operand-issuing controller and a result consumer where area matters more than latency.

---
 rtl/multicycle_adder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_adder.sv
// -----------------------------------------------------------------------------
// multicycle_adder
//
// Purpose:
//    Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk
//    first, through a registered carry. It trades latency (N = WIDTH/CHUNK
//    cycles) for a narrow CHUNK-bit adder. A start/done handshake frames each
//    operation. Carry, signed-overflow and zero flags are produced with the
//    result.
//
// Ports:
//    clk       in   rising-edge clock
//    reset_n   in   asynchronous active-low reset
//    start     in   request, honoured only while busy = 0
//    a, b      in   WIDTH-bit operands, captured on accept
//    carryin   in   carry into bit 0 for add (ignored for subtract)
//    subtract  in   1 selects a - b, captured on accept
//    busy      out  operation in progress
//    done      out  one-cycle pulse when the result outputs update
//    sum       out  WIDTH-bit result, held until the next done
//    carryout  out  carry out of the MSB (subtract: 1 = no borrow)
//    overflow  out  two's-complement overflow
//    zero      out  sum == 0
// -----------------------------------------------------------------------------
module multicycle_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carryin,
   input  logic             subtract,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carryout,
   output logic             overflow,
   output logic             zero
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("multicycle_adder: WIDTH must be >= 2 and CHUNK must be >= 1 and divide WIDTH");
      end
   endgenerate

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;          // already inverted for subtract
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] psum_q, psum_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carryout_q, carryout_d;
   logic             overflow_q, overflow_d;
   logic             zero_q, zero_d;
   logic             done_q, done_d;

   // Chunk datapath: the operand registers are shifted right each cycle, so
   // the current chunk always sits in the low CHUNK bits.
   logic [CHUNK:0]   csum;
   logic [WIDTH-1:0] csum_ext;
   logic [WIDTH-1:0] psum_next;
   logic             msb_cin;
   logic             last_chunk;

   always_comb begin
      csum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
      csum_ext = WIDTH'(csum[CHUNK-1:0]);
      // Partial sum fills from the top; after N chunks it is the full result.
      psum_next = (psum_q >> CHUNK) | (csum_ext << (WIDTH - CHUNK));
      // Carry into the chunk's top bit recovered from that bit's sum and inputs;
      // on the final chunk this is the carry into bit WIDTH-1.
      msb_cin = csum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
      last_chunk = (cnt_q == CW'(N - 1));
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      carry_d    = carry_q;
      cnt_d      = cnt_q;
      psum_d     = psum_q;
      sum_d      = sum_q;
      carryout_d = carryout_q;
      overflow_d = overflow_q;
      zero_d     = zero_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = subtract ? ~b : b;
               carry_d = subtract ? 1'b1 : carryin;
               cnt_d   = '0;
               psum_d  = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            carry_d = csum[CHUNK];
            psum_d  = psum_next;
            cnt_d   = cnt_q + CW'(1);
            if (last_chunk) begin
               cnt_d      = '0;
               sum_d      = psum_next;
               carryout_d = csum[CHUNK];
               overflow_d = msb_cin ^ csum[CHUNK];
               zero_d     = (psum_next == '0);
               done_d     = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         carry_q    <= 1'b0;
         cnt_q      <= '0;
         psum_q     <= '0;
         sum_q      <= '0;
         carryout_q <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         carry_q    <= carry_d;
         cnt_q      <= cnt_d;
         psum_q     <= psum_d;
         sum_q      <= sum_d;
         carryout_q <= carryout_d;
         overflow_q <= overflow_d;
         zero_q     <= zero_d;
         done_q     <= done_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign sum      = sum_q;
   assign carryout = carryout_q;
   assign overflow = overflow_q;
   assign zero     = zero_q;

endmodule
